// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer and its surroundings.
// The slave side is the controller; the master side drives scan, buttons and strobes.
interface pong_game_ctrl_if;
  logic [1:0] btn;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] state;
  logic [1:0] ball;
  logic [3:0] dig1;
  logic [3:0] dig0;

  modport master (
    output btn, pix_x, pix_y, hit, miss,
    input  gra_still, state, ball, dig1, dig0
  );

  modport slave (
    input  btn, pix_x, pix_y, hit, miss,
    output gra_still, state, ball, dig1, dig0
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball count, BCD score and inter-ball/game-over pauses.
// Drives gra_still to freeze the playfield outside active play.
module pong_game_ctrl #(
  parameter int NUM_BALLS   = 3,
  parameter int TIMER_TICKS = 120,
  parameter int TICK_Y      = 481
) (
  input  logic               clk,
  input  logic               reset,
  pong_game_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

  localparam logic [1:0] BALL_LOAD  = 2'(NUM_BALLS);
  localparam logic [6:0] TIMER_LOAD = 7'(TIMER_TICKS);

  state_e     state_q, state_d;
  logic [1:0] ball_q, ball_d;
  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig0_q, dig0_d;
  logic [6:0] timer_q, timer_d;
  logic       hit_q, miss_q;

  logic refr_tick, timer_up, hit_p, miss_p, score_max, btn_any;

  assign refr_tick = (bus.pix_y == 10'(TICK_Y)) && (bus.pix_x == 10'd0);
  assign timer_up  = (timer_q == 7'd0);
  assign hit_p     = bus.hit & ~hit_q;
  assign miss_p    = bus.miss & ~miss_q;
  assign score_max = (dig1_q == 4'd9) && (dig0_q == 4'd9);
  assign btn_any   = (bus.btn != 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_NEWGAME;
      ball_q  <= BALL_LOAD;
      dig1_q  <= 4'd0;
      dig0_q  <= 4'd0;
      timer_q <= 7'd0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ball_q  <= ball_d;
      dig1_q  <= dig1_d;
      dig0_q  <= dig0_d;
      timer_q <= timer_d;
      hit_q   <= bus.hit;
      miss_q  <= bus.miss;
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ball_d  = ball_q;
    dig1_d  = dig1_q;
    dig0_d  = dig0_q;
    timer_d = (refr_tick && !timer_up) ? timer_q - 7'd1 : timer_q;

    case (state_q)
      ST_NEWGAME: begin
        if (btn_any) begin
          state_d = ST_PLAY;
          ball_d  = BALL_LOAD;
          dig1_d  = 4'd0;
          dig0_d  = 4'd0;
        end
      end
      ST_PLAY: begin
        // A miss outranks a simultaneous hit; that hit is lost.
        if (miss_p) begin
          timer_d = TIMER_LOAD;
          ball_d  = ball_q - 2'd1;
          state_d = (ball_q == 2'd1) ? ST_OVER : ST_NEWBALL;
        end else if (hit_p && !score_max) begin
          if (dig0_q == 4'd9) begin
            dig0_d = 4'd0;
            dig1_d = dig1_q + 4'd1;
          end else begin
            dig0_d = dig0_q + 4'd1;
          end
        end
      end
      ST_NEWBALL: begin
        if (timer_up && btn_any) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (timer_up) state_d = ST_NEWGAME;
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  always_comb begin
    bus.gra_still = (state_q != ST_PLAY);
    bus.state     = state_q;
    bus.ball      = ball_q;
    bus.dig1      = dig1_q;
    bus.dig0      = dig0_q;
  end

endmodule
